// File: rtl/hdlc_frame_tx_if.sv
// Buffer-write, start and line-side signals of the HDLC frame transmitter.
interface hdlc_frame_tx_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              buf_wen;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              tx_start;
    logic [ADDR_W:0]   tx_len;
    logic              line_clk;
    logic              line_data;
    logic              busy;
    logic              done;
    logic              len_err;

    // Host side: fills the buffer and starts frames, watches the line.
    modport master (
        output buf_wen, buf_addr, buf_wdata, tx_start, tx_len,
        input  line_clk, line_data, busy, done, len_err
    );

    // Transmitter side.
    modport slave (
        input  buf_wen, buf_addr, buf_wdata, tx_start, tx_len,
        output line_clk, line_data, busy, done, len_err
    );
endinterface

// File: rtl/hdlc_frame_tx.sv
// HDLC frame transmitter: flag, bit-stuffed payload, CRC-16/X.25 FCS, flag,
// serialised LSB first with a self-generated line clock.
module hdlc_frame_tx #(
    parameter int unsigned CLK_DIV = 50,
    parameter int unsigned ADDR_W  = 9
) (
    input logic              clk_100m,
    input logic              rst_n,
    hdlc_frame_tx_if.slave   bus
);
    localparam int unsigned BcntW = $clog2(CLK_DIV);
    localparam logic [7:0]  Flag  = 8'h7E;

    typedef enum logic [2:0] {StIdle, StOpen, StData, StFcs, StClose} state_e;

    state_e            state_q, state_d;
    logic [BcntW-1:0]  bcnt_q;
    logic              bit_tick;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        byte_q, byte_d;
    logic [15:0]       crc_q, crc_d;
    logic [2:0]        ones_q, ones_d;
    logic              line_data_q, line_data_d;
    logic              done_q, done_d;
    logic              len_err_q, len_err_d;
    logic              busy;
    logic              len_ok;
    logic              tx_bit;
    logic [7:0]        mem [2**ADDR_W];
    logic [7:0]        ram_rdata;

    assign bit_tick = (bcnt_q == BcntW'(CLK_DIV - 1));
    assign busy     = (state_q != StIdle);
    // 1..2^ADDR_W: either exactly 2^ADDR_W, or nonzero with the top bit clear.
    assign len_ok   = bus.tx_len[ADDR_W] ? (bus.tx_len[ADDR_W-1:0] == '0) : (bus.tx_len != '0);

    assign bus.line_clk  = (bcnt_q >= BcntW'(CLK_DIV / 2));
    assign bus.line_data = line_data_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.len_err   = len_err_q;

    // Free-running bit-timing counter.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
        end else if (bit_tick) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_q + 1'b1;
        end
    end

    // Payload buffer; host writes are locked out while a frame is in flight.
    always_ff @(posedge clk_100m) begin
        if (bus.buf_wen && !busy) begin
            mem[bus.buf_addr] <= bus.buf_wdata;
        end
        ram_rdata <= mem[rd_addr_q];
    end

    // Frame state and datapath registers.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_idx_q   <= '0;
            byte_cnt_q  <= '0;
            len_q       <= '0;
            rd_addr_q   <= '0;
            byte_q      <= '0;
            crc_q       <= 16'hFFFF;
            ones_q      <= '0;
            line_data_q <= 1'b1;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            rd_addr_q   <= rd_addr_d;
            byte_q      <= byte_d;
            crc_q       <= crc_d;
            ones_q      <= ones_d;
            line_data_q <= line_data_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
        end
    end

    // Next-state: every bit_tick chooses the bit shown for the following bit period.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        byte_cnt_d  = byte_cnt_q;
        len_d       = len_q;
        rd_addr_d   = rd_addr_q;
        byte_d      = byte_q;
        crc_d       = crc_q;
        ones_d      = ones_q;
        line_data_d = line_data_q;
        done_d      = 1'b0;
        len_err_d   = 1'b0;
        tx_bit      = 1'b1;
        case (state_q)
            StIdle: begin
                line_data_d = 1'b1;
                if (bus.tx_start) begin
                    if (len_ok) begin
                        state_d    = StOpen;
                        len_d      = bus.tx_len;
                        rd_addr_d  = '0;
                        byte_cnt_d = '0;
                        bit_idx_d  = '0;
                        crc_d      = 16'hFFFF;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            StOpen: begin
                if (bit_tick) begin
                    line_data_d = Flag[bit_idx_q[2:0]];
                    if (bit_idx_q == 4'd7) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                        ones_d    = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (bit_tick) begin
                    if (ones_q == 3'd5) begin
                        line_data_d = 1'b0;
                        ones_d      = '0;
                    end else begin
                        // Bit 0 comes straight from the prefetched RAM word; the
                        // address then advances so the next byte is ready in time.
                        if (bit_idx_q == 4'd0) begin
                            tx_bit    = ram_rdata[0];
                            byte_d    = {1'b0, ram_rdata[7:1]};
                            rd_addr_d = rd_addr_q + 1'b1;
                        end else begin
                            tx_bit = byte_q[0];
                            byte_d = {1'b0, byte_q[7:1]};
                        end
                        line_data_d = tx_bit;
                        ones_d      = tx_bit ? ones_q + 3'd1 : 3'd0;
                        crc_d       = (crc_q >> 1) ^ ((crc_q[0] ^ tx_bit) ? 16'h8408 : 16'h0000);
                        if (bit_idx_q == 4'd7) begin
                            bit_idx_d  = '0;
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            if (byte_cnt_q + 1'b1 == len_q) begin
                                state_d = StFcs;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
            end
            StFcs: begin
                if (bit_tick) begin
                    if (ones_q == 3'd5) begin
                        line_data_d = 1'b0;
                        ones_d      = '0;
                    end else begin
                        // CRC register is consumed as the FCS shift register.
                        tx_bit      = ~crc_q[0];
                        crc_d       = {1'b1, crc_q[15:1]};
                        line_data_d = tx_bit;
                        ones_d      = tx_bit ? ones_q + 3'd1 : 3'd0;
                        if (bit_idx_q == 4'd15) begin
                            state_d   = StClose;
                            bit_idx_d = '0;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
            end
            StClose: begin
                if (bit_tick) begin
                    if (bit_idx_q == 4'd0 && ones_q == 3'd5) begin
                        // Pending stuff bit from the tail of the FCS.
                        line_data_d = 1'b0;
                        ones_d      = '0;
                    end else if (bit_idx_q == 4'd8) begin
                        line_data_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        line_data_d = Flag[bit_idx_q[2:0]];
                        bit_idx_d   = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_hdlc_frame_tx.sv
// Scoreboard bench for hdlc_frame_tx: stimulus queues the expected line bits,
// a monitor samples line_data on each rising line_clk and compares.
module tb_hdlc_frame_tx;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned ADDR_W  = 9;

    logic clk_100m = 1'b0;
    logic rst_n    = 1'b0;

    hdlc_frame_tx_if #(.ADDR_W(ADDR_W)) bus ();

    hdlc_frame_tx #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk_100m = ~clk_100m;

    int         total = 0;
    int         bad   = 0;
    int         done_cnt = 0;
    int         bit_cnt  = 0;
    logic       exp_q[$];
    logic [7:0] img [512];
    logic       in_frame  = 1'b0;
    logic       lclk_prev = 1'b0;

    // Monitor: frame starts at the first 0 while busy; sample at mid-bit.
    always @(negedge clk_100m) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            lclk_prev = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL frame_len: %0d expected bits still queued at done, required 0",
                             exp_q.size());
                end
            end
            if (!bus.busy) in_frame = 1'b0;
            else if (!in_frame && !bus.line_data) in_frame = 1'b1;
            if (in_frame && bus.line_clk && !lclk_prev) begin
                logic e;
                total++;
                bit_cnt++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL line_bit: unexpected extra bit %0b, required none", bus.line_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.line_data !== e) begin
                        bad++;
                        $display("FAIL line_bit #%0d: got %0b, required %0b", bit_cnt,
                                 bus.line_data, e);
                    end
                end
            end
            lclk_prev = bus.line_clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100m);
            #1;
        end
    endtask

    task automatic write_byte(input int a, input logic [7:0] d);
        bus.buf_wen   = 1'b1;
        bus.buf_addr  = a[ADDR_W-1:0];
        bus.buf_wdata = d;
        tick(1);
        bus.buf_wen   = 1'b0;
    endtask

    task automatic load_img(input int len);
        for (int i = 0; i < len; i++) write_byte(i, img[i]);
    endtask

    task automatic pulse_start(input int len);
        bus.tx_start = 1'b1;
        bus.tx_len   = len[ADDR_W:0];
        tick(1);
        bus.tx_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit stuff, inout int ones);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            if (stuff) begin
                ones = b[i] ? ones + 1 : 0;
                if (ones == 5) begin
                    exp_q.push_back(1'b0);
                    ones = 0;
                end
            end
        end
    endtask

    task automatic expect_frame(input int len, input logic [15:0] fcs);
        int ones = 0;
        logic [7:0] flag = 8'h7E;
        push_byte(flag, 1'b0, ones);
        for (int i = 0; i < len; i++) push_byte(img[i], 1'b1, ones);
        push_byte(fcs[7:0], 1'b1, ones);
        push_byte(fcs[15:8], 1'b1, ones);
        push_byte(flag, 1'b0, ones);
    endtask

    function automatic logic [15:0] fcs_model(input int len);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < len; i++)
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ img[i][j]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return ~c;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n  = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL %s: done count %0d after %0d cycles, required %0d", name, done_cnt,
                     budget, d0 + 1);
        end
    endtask

    task automatic load_123(input int len);
        for (int i = 0; i < 9; i++) img[i] = 8'h31 + 8'(i);
        load_img(len);
    endtask

    initial begin
        int d0;
        int b0;
        int n;
        bus.buf_wen   = 1'b0;
        bus.buf_addr  = '0;
        bus.buf_wdata = '0;
        bus.tx_start  = 1'b0;
        bus.tx_len    = '0;
        tick(3);
        check("rst_line_data", 32'(bus.line_data), 32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_len_err",   32'(bus.len_err),   32'd0);
        check("rst_line_clk",  32'(bus.line_clk),  32'd0);
        rst_n = 1'b1;
        tick(2);

        // "123456789": FCS 0x906E, low byte first.
        load_123(9);
        expect_frame(9, 16'h906E);
        d0 = done_cnt;
        pulse_start(9);
        check("busy_rise", 32'(bus.busy), 32'd1);
        wait_done("frame_123", 2000);
        check("busy_fall", 32'(bus.busy), 32'd0);
        check("idle_mark", 32'(bus.line_data), 32'd1);
        tick(20);
        check("done_once_123", 32'(done_cnt - d0), 32'd1);

        // 0xFF: CRC 0x00FF, FCS 0xFF00; stuffing in payload and FCS.
        img[0] = 8'hFF;
        write_byte(0, img[0]);
        expect_frame(1, 16'hFF00);
        pulse_start(1);
        wait_done("frame_ff", 1000);
        tick(5);

        // 0x7E written in the same cycle as the start: FCS 0x6A81.
        img[0] = 8'h7E;
        expect_frame(1, 16'h6A81);
        bus.buf_wen   = 1'b1;
        bus.buf_addr  = '0;
        bus.buf_wdata = 8'h7E;
        pulse_start(1);
        bus.buf_wen   = 1'b0;
        check("busy_rise_7e", 32'(bus.busy), 32'd1);
        wait_done("frame_7e", 1000);
        tick(5);

        // Length rejections.
        pulse_start(0);
        check("len0_err",  32'(bus.len_err), 32'd1);
        check("len0_busy", 32'(bus.busy),    32'd0);
        tick(1);
        check("len0_err_pulse", 32'(bus.len_err),   32'd0);
        check("len0_mark",      32'(bus.line_data), 32'd1);
        pulse_start(513);
        check("len513_err",  32'(bus.len_err), 32'd1);
        check("len513_busy", 32'(bus.busy),    32'd0);
        tick(1);
        check("len513_err_pulse", 32'(bus.len_err),   32'd0);
        tick(10);
        check("len_rej_mark", 32'(bus.line_data), 32'd1);

        // Start while busy is ignored.
        load_123(9);
        expect_frame(9, 16'h906E);
        d0 = done_cnt;
        pulse_start(9);
        tick(100);
        pulse_start(3);
        check("busy_start_no_err", 32'(bus.len_err), 32'd0);
        wait_done("frame_busy_start", 2000);
        tick(60);
        check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
        check("busy_start_idle",     32'(bus.busy),      32'd0);

        // Full buffer; mid-frame writes must be dropped.
        for (int i = 0; i < 512; i++) img[i] = 8'((i * 37 + 11) & 255);
        load_img(512);
        expect_frame(512, fcs_model(512));
        pulse_start(512);
        tick(300);
        for (int i = 0; i < 8; i++) write_byte(100 + i * 50, 8'hA5);
        wait_done("frame_512", 40000);
        tick(5);

        // Reset during payload byte 4 of a 9-byte frame.
        load_123(9);
        expect_frame(9, 16'h906E);
        d0 = done_cnt;
        b0 = bit_cnt;
        pulse_start(9);
        n = 0;
        while (bit_cnt - b0 < 42 && n < 2000) begin
            tick(1);
            n++;
        end
        check("reach_byte4", 32'(bit_cnt - b0 >= 42), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("abort_line_data", 32'(bus.line_data), 32'd1);
        check("abort_busy",      32'(bus.busy),      32'd0);
        tick(2);
        exp_q.delete();
        rst_n = 1'b1;
        tick(100);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle",    32'(bus.busy),      32'd0);
        load_123(9);
        expect_frame(9, 16'h906E);
        pulse_start(9);
        wait_done("frame_after_reset", 2000);
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
